// File: rtl/decoder_pkg.sv
// Shared constants and state type for the 4-bit code to one-hot decoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package decoder_pkg;

  localparam logic [3:0] CODE_MIN = 4'd1;
  localparam logic [3:0] CODE_MAX = 4'd10;
  localparam int         DATA_W   = 10;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/decoder4to10_map.sv
// Combinational code-to-one-hot map with a legality flag (codes 1..10 legal).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when the result is used.
module decoder4to10_map
  import decoder_pkg::*;
(
  input  logic [3:0]        i_code,
  output logic [DATA_W-1:0] o_onehot,
  output logic              o_legal
);

  // Code n lights bit n-1; illegal codes produce an all-zero word.
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o_onehot[i] = (i_code == 4'(i + 1));
    end
    o_legal = (i_code >= CODE_MIN) && (i_code <= CODE_MAX);
  end

endmodule

// File: rtl/decoder4to10.sv
// Registered 4-bit code to 10-bit one-hot decoder with hold timer and illegal-code counter.
// Latency: one cycle from accept to o_data / o_err; o_data held for HOLD_CYCLES cycles.
// Backpressure: o_ready low while a word is held; illegal codes never stall the input.
module decoder4to10
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [3:0]        i_code,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_err_cnt,
  input  logic              i_err_clr
);

  // Hold counter counts HOLD_CYCLES-1 down to 0, so clog2 bits suffice (min 1).
  localparam int             CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]  HOLD_INIT = CW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e              state_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;
  logic [CNT_W-1:0]    err_cnt_q;
  logic [CNT_W-1:0]    err_cnt_d;
  logic [CW-1:0]       hold_q;

  logic [DATA_W-1:0]   map_onehot;
  logic                map_legal;
  logic                xfer;
  logic                bad_xfer;

  decoder4to10_map u_map (
    .i_code   (i_code),
    .o_onehot (map_onehot),
    .o_legal  (map_legal)
  );

  assign o_ready  = (state_q == IDLE);
  assign xfer     = i_valid && o_ready;
  assign bad_xfer = xfer && !map_legal;

  // Saturating illegal-code count; a clear on the same edge overrides the increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bad_xfer && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
    if (i_err_clr) begin
      err_cnt_d = '0;
    end
  end

  // FSM: accept in IDLE, hold the one-hot word for HOLD_CYCLES cycles, then release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      hold_q    <= '0;
    end else begin
      err_q     <= bad_xfer;
      err_cnt_q <= err_cnt_d;
      case (state_q)
        IDLE: begin
          if (xfer && map_legal) begin
            data_q  <= map_onehot;
            hold_q  <= HOLD_INIT;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else begin
            data_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          data_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_data    = data_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_decoder4to10.sv
// Bench for decoder4to10: two instances (HOLD=4/CNT_W=8 and HOLD=1/CNT_W=2).
// Latency: checks every cycle against a cycle-level behavioural model.
// Backpressure: model tracks o_ready from the remaining hold time.
module tb_decoder4to10;

  logic       clk = 1'b0;
  logic       rst;

  logic       a_valid, a_clr, a_ready, a_err;
  logic [3:0] a_code;
  logic [9:0] a_data;
  logic [7:0] a_cnt;

  logic       b_valid, b_clr, b_ready, b_err;
  logic [3:0] b_code;
  logic [9:0] b_data;
  logic [1:0] b_cnt;

  int total = 0;
  int bad   = 0;

  // model state per instance: remaining held cycles, held code, error pulse, count
  int m_rem  [2];
  int m_code [2];
  int m_err  [2];
  int m_cnt  [2];
  int m_hold [2] = '{4, 1};
  int m_cmax [2] = '{255, 3};

  typedef struct {
    logic [3:0] code;
    logic [9:0] exp_data;
    logic       exp_err;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  decoder4to10 #(.HOLD_CYCLES(4), .CNT_W(8)) u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .i_code(a_code),
    .o_ready(a_ready), .o_data(a_data), .o_err(a_err), .o_err_cnt(a_cnt),
    .i_err_clr(a_clr)
  );

  decoder4to10 #(.HOLD_CYCLES(1), .CNT_W(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .i_code(b_code),
    .o_ready(b_ready), .o_data(b_data), .o_err(b_err), .o_err_cnt(b_cnt),
    .i_err_clr(b_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rem[d] = 0; m_code[d] = 1; m_err[d] = 0; m_cnt[d] = 0;
    end
  endtask

  // One rising edge of the behavioural model for instance d.
  task automatic model_step(input int d, input logic v, input logic [3:0] c, input logic clr);
    m_err[d] = 0;
    if (m_rem[d] > 0) begin
      m_rem[d]--;
    end else if (v) begin
      if (c >= 1 && c <= 10) begin
        m_rem[d]  = m_hold[d];
        m_code[d] = c;
      end else begin
        m_err[d] = 1;
        if (m_cnt[d] < m_cmax[d]) m_cnt[d]++;
      end
    end
    if (clr) m_cnt[d] = 0;
  endtask

  function automatic logic [9:0] m_data(input int d);
    logic [9:0] one;
    one = 10'd1;
    return (m_rem[d] > 0) ? (one << (m_code[d] - 1)) : 10'd0;
  endfunction

  task automatic compare_all();
    chk("a_data",  a_data,  m_data(0));
    chk("a_ready", a_ready, (m_rem[0] == 0));
    chk("a_err",   a_err,   m_err[0]);
    chk("a_cnt",   a_cnt,   m_cnt[0]);
    chk("b_data",  b_data,  m_data(1));
    chk("b_ready", b_ready, (m_rem[1] == 0));
    chk("b_err",   b_err,   m_err[1]);
    chk("b_cnt",   b_cnt,   m_cnt[1]);
  endtask

  // Advance one clock; inputs are driven at the negedge, outputs compared at the next negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_step(0, a_valid, a_code, a_clr);
      model_step(1, b_valid, b_code, b_clr);
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    tbl[0]  = '{4'd0,  10'b0000000000, 1'b1};
    tbl[1]  = '{4'd1,  10'b0000000001, 1'b0};
    tbl[2]  = '{4'd2,  10'b0000000010, 1'b0};
    tbl[3]  = '{4'd3,  10'b0000000100, 1'b0};
    tbl[4]  = '{4'd4,  10'b0000001000, 1'b0};
    tbl[5]  = '{4'd5,  10'b0000010000, 1'b0};
    tbl[6]  = '{4'd6,  10'b0000100000, 1'b0};
    tbl[7]  = '{4'd7,  10'b0001000000, 1'b0};
    tbl[8]  = '{4'd8,  10'b0010000000, 1'b0};
    tbl[9]  = '{4'd9,  10'b0100000000, 1'b0};
    tbl[10] = '{4'd10, 10'b1000000000, 1'b0};
    tbl[11] = '{4'd11, 10'b0000000000, 1'b1};
    tbl[12] = '{4'd12, 10'b0000000000, 1'b1};
    tbl[13] = '{4'd13, 10'b0000000000, 1'b1};
    tbl[14] = '{4'd14, 10'b0000000000, 1'b1};
    tbl[15] = '{4'd15, 10'b0000000000, 1'b1};

    rst = 1'b1;
    a_valid = 0; a_code = 0; a_clr = 0;
    b_valid = 0; b_code = 0; b_clr = 0;
    model_reset();
    #2;
    compare_all();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // code 3 for one cycle: bit 2 for exactly 4 cycles
    a_valid = 1; a_code = 4'd3;
    tick();
    a_valid = 0; a_code = 4'd9;
    for (int i = 0; i < 3; i++) begin
      chk("t1_data_held", a_data, 10'b0000000100);
      chk("t1_ready_low", a_ready, 1'b0);
      tick();
    end
    chk("t1_data_last", a_data, 10'b0000000100);
    tick();
    chk("t1_data_clear", a_data, 10'd0);
    chk("t1_ready_back", a_ready, 1'b1);

    // sweep 1..10 with valid held high: one accept every 5 cycles
    a_valid = 1;
    for (int c = 1; c <= 10; c++) begin
      a_code = 4'(c);
      tick();
      chk("sweep_data", a_data, 32'(1) << (c - 1));
      chk("sweep_err", a_err, 1'b0);
      for (int i = 0; i < 4; i++) tick();
    end
    a_valid = 0;
    tick();

    // illegal codes back to back
    a_valid = 1;
    a_code = 4'd0;  tick(); chk("ill_err0", a_err, 1'b1); chk("ill_rdy0", a_ready, 1'b1);
    a_code = 4'd11; tick(); chk("ill_err1", a_err, 1'b1); chk("ill_data1", a_data, 10'd0);
    a_code = 4'd15; tick(); chk("ill_err2", a_err, 1'b1); chk("ill_cnt", a_cnt, 8'd3);
    a_valid = 0;
    tick(); chk("ill_err_off", a_err, 1'b0);

    // table: every code in IDLE
    for (int i = 0; i < 16; i++) begin
      a_valid = 1; a_code = tbl[i].code;
      tick();
      chk("tbl_data", a_data, tbl[i].exp_data);
      chk("tbl_err", a_err, tbl[i].exp_err);
      a_valid = 0;
      for (int j = 0; j < 5; j++) tick();
    end
    chk("tbl_cnt", a_cnt, 8'd9);
    a_clr = 1; tick(); a_clr = 0;
    chk("a_clr", a_cnt, 8'd0);

    // CNT_W=2 saturation then clear racing an illegal code
    b_valid = 1; b_code = 4'd13;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_cnt", b_cnt, 2'd3);
    b_clr = 1; b_code = 4'd0;
    tick();
    chk("clr_wins_cnt", b_cnt, 2'd0);
    chk("clr_err_pulse", b_err, 1'b1);
    b_clr = 0; b_valid = 0;
    tick();
    chk("clr_err_once", b_err, 1'b0);

    // reset mid-HOLD
    a_valid = 1; a_code = 4'd10;
    tick();
    a_valid = 0;
    tick();
    tick();
    chk("pre_rst_data", a_data, 10'b1000000000);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_immediate", a_data, 10'd0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    chk("rst_ready", a_ready, 1'b1);
    a_valid = 1; a_code = 4'd1;
    tick();
    chk("post_rst_accept", a_data, 10'b0000000001);
    a_valid = 0;
    for (int i = 0; i < 4; i++) tick();

    // HOLD_CYCLES=1: code 7 then 2 with valid held
    b_valid = 1; b_code = 4'd7;
    tick();
    chk("h1_bit6", b_data, 10'b0001000000);
    chk("h1_rdy_lo", b_ready, 1'b0);
    b_code = 4'd2;
    tick();
    chk("h1_gap", b_data, 10'd0);
    chk("h1_rdy_hi", b_ready, 1'b1);
    tick();
    chk("h1_bit1", b_data, 10'b0000000010);
    b_valid = 0;
    tick();

    // randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      a_code  = 4'($urandom_range(0, 15));
      a_clr   = ($urandom_range(0, 15) == 0);
      b_valid = 1'($urandom_range(0, 1));
      b_code  = 4'($urandom_range(0, 15));
      b_clr   = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder4to10.md
# decoder4to10

Registered 4-bit-code to 10-bit one-hot decoder: the receive-side counterpart of the 10-to-4 one-hot encoder. It accepts codes 1..10 over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. It flags and counts codes outside 1..10. It sits downstream of the encoder, after any register or link stage, and drives one-hot select or indicator lines.

## Interface
- HOLD_CYCLES, default 4: cycles each decoded one-hot word is held; legal range ≥ 1.
- CNT_W, default 8: width of the error counter.

- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  i_code is valid this cycle.
- i_code  input  4  code to decode; legal values are 4'd1..4'd10.
- o_ready  output  1  block can accept a code this cycle.
- o_data  output  10  registered one-hot output; all zeros when idle.
- o_err  output  1  one-cycle pulse after an illegal code is accepted.
- o_err_cnt  output  CNT_W  saturating count of illegal codes accepted.
- i_err_clr  input  1  synchronous clear of o_err_cnt.

## Operation
- States: IDLE and HOLD.
- o_ready = (state == IDLE), driven combinationally from the state register.
- Transfer: a code transfers on any rising edge where i_valid && o_ready. i_code is ignored at all other times.
- Legal code c (1..10) transferred in IDLE:
  - o_data ← 10'b1 << (c−1), so code 1 → bit 0 and code 10 → bit 9.
  - Hold counter ← HOLD_CYCLES−1; next state is HOLD.
- Illegal code (0, 11..15) transferred in IDLE:
  - o_data stays 0 and the state stays IDLE.
  - o_err = 1 for exactly the next cycle.
  - o_err_cnt increments by 1 and saturates at all-ones.
- HOLD:
  - o_data is held; i_valid is ignored.
  - If the counter ≠ 0, decrement it. If the counter = 0, clear o_data and go to IDLE.
- i_err_clr:
  - o_err_cnt ← 0 on the next edge.
  - If i_err_clr coincides with an illegal transfer, the clear wins (count = 0), but o_err still pulses.
- Counter width: $clog2(HOLD_CYCLES), minimum 1 bit.
- Reset (any time, including mid-HOLD): immediately state = IDLE, o_data = 0, o_err = 0, o_err_cnt = 0, counter = 0. o_ready is therefore 1 during reset, but no transfer occurs while i_rst is high.

## Timing
- Legal code accepted at edge k:
  - o_data is one-hot from after edge k to edge k+HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles.
  - o_ready is 0 over the same window and 1 again from after edge k+HOLD_CYCLES.
- Next accept: the earliest following transfer is at edge k+HOLD_CYCLES+1, so throughput is one code per HOLD_CYCLES+1 cycles.
- Illegal code accepted at edge k:
  - o_err = 1 from after edge k to edge k+1.
  - o_err_cnt is updated after edge k.
  - o_ready stays 1, so back-to-back illegal codes are accepted every cycle.
- HOLD_CYCLES = 1: o_data is high for one cycle, o_ready low for one cycle.
- No combinational path from i_code or i_valid to any output.

## Structure
- Package decoder_pkg holds:
  - CODE_MIN = 4'd1 and CODE_MAX = 4'd10.
  - DATA_W = 10.
  - The state enum {IDLE, HOLD}.
- Sub-module decoder4to10_map: purely combinational, i_code[3:0] → one-hot [9:0] plus a legal flag. The top level registers its outputs and runs the FSM, hold counter and error counter.

## Test plan
- Reset release, HOLD_CYCLES=4, code 4'd3 valid for one cycle → o_data = 10'b0000000100 for exactly 4 cycles, o_ready low for those 4, then o_data = 0 and o_ready = 1.
- Sweep codes 1..10 with i_valid held high → each code maps to bit code−1; a new code is accepted every 5 cycles; o_err never asserts.
- Codes 0, 11 and 15 back to back → o_err high 3 consecutive cycles, o_err_cnt = 3, o_data stays 0, o_ready stays 1.
- CNT_W=2, 5 illegal codes → o_err_cnt saturates at 3. Then i_err_clr together with a sixth illegal code → o_err_cnt = 0 and o_err pulses once.
- Code 4'd10 accepted, i_rst asserted 2 cycles later (mid-HOLD) → o_data = 0 immediately. After release, o_ready = 1 and code 4'd1 is accepted normally.
- HOLD_CYCLES=1, code 4'd7 then code 4'd2 with i_valid held → bit 6 for 1 cycle, 1 idle cycle, bit 1 for 1 cycle.
